acc_ctrl: RTL and testbench
===========================

// Module: acc_ctrl
// PURPOSE
//  Sequences the matrix-multiply accelerator (top_acc / multiply_long) for the core.
//  Exposes a small memory-mapped register file on a req/gnt/rvalid register bus.
//  Drives the accelerator start level, tracks completion and measures run length in cycles.
//  Enforces an optional timeout and raises a level interrupt when a run finishes.
// PARAMETERS
//  CNT_W      32  width of cycle counter and timeout limit (<=32)
//  ADDR_W      4  byte-address width of register window (regs at 0x0,0x4,0x8,0xC)
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       asynchronous active-low reset
//  reg_req_i     in   1       register access request
//  reg_we_i      in   1       1=write, 0=read
//  reg_addr_i    in   ADDR_W  byte address; bits [1:0] ignored
//  reg_wdata_i   in   32      write data
//  reg_gnt_o     out  1       grant; combinational = reg_req_i (always ready)
//  reg_rvalid_o  out  1       response valid, 1 cycle after granted access (reads and writes)
//  reg_rdata_o   out  32      read data, valid with reg_rvalid_o, 0 for writes/unmapped
//  acc_start_o   out  1       start level to accelerator
//  acc_done_i    in   1       done level from accelerator
//  irq_o         out  1       interrupt = IRQ_EN & (DONE | TIMEOUT)
// BEHAVIOUR
//  Registers:
//   0x0 CTRL   [0] START w1 self-clearing, reads 0; [1] IRQ_EN rw; [2] ABORT w1, reads 0
//   0x4 STATUS [0] BUSY ro; [1] DONE sticky W1C; [2] TIMEOUT sticky W1C
//   0x8 CYCLES ro: cycles spent in RUN for last run (frozen until next START)
//   0xC TLIMIT rw: timeout limit in cycles; 0 disables timeout
//  Reset: FSM=IDLE, acc_start_o=0, irq_o=0, reg_rvalid_o=0, reg_rdata_o=0, all regs 0.
//  FSM (state enum IDLE, RUN, DRAIN):
//   IDLE : START write with acc_done_i==0 -> RUN next cycle; clears CYCLES, DONE, TIMEOUT.
//          START while acc_done_i==1 ignored (accelerator not yet released).
//   RUN  : acc_start_o=1, BUSY=1, CYCLES increments each cycle (saturates at all-ones).
//          acc_done_i==1 -> DRAIN, set DONE. Else ABORT write, or TLIMIT!=0 and
//          CYCLES==TLIMIT-1 -> DRAIN, set TIMEOUT. done wins over timeout/abort same cycle.
//   DRAIN: acc_start_o=0, BUSY=1; wait acc_done_i==0 -> IDLE. No timeout in DRAIN.
//  START written while BUSY is ignored; ABORT outside RUN is ignored.
//  W1C to DONE/TIMEOUT in the same cycle as the FSM sets it: set wins.
//  acc_start_o is registered (asserted first cycle in RUN, drops first cycle in DRAIN).
//  Min run latency: START write cycle -> acc_start_o high next cycle.
//  Writes to TLIMIT during RUN take effect immediately.
//  Reset mid-run: all state cleared asynchronously; acc_start_o drops at once.
//  Unmapped addresses: writes ignored, reads return 0; no error response.
// STRUCTURE
//  Package acc_pkg: register offsets (ACC_CTRL_OFFS..ACC_TLIMIT_OFFS), CTRL/STATUS bit
//  indices, acc_state_e enum {IDLE,RUN,DRAIN}.
//  One sub-module acc_ctrl_regs: bus decode, register storage, rvalid/rdata pipeline;
//  emits start/abort pulses, consumes set-strobes for DONE/TIMEOUT. FSM+counter in acc_ctrl.
// TESTING
//  1 Write TLIMIT=0, CTRL=0x3; model asserts done 10 cycles after start -> acc_start_o
//    high 11 cycles, STATUS reads 0x2 then 0x3->0x2 after release, CYCLES=11, irq_o=1.
//  2 TLIMIT=5, accelerator never done -> acc_start_o high exactly 5 cycles, STATUS=0x4,
//    CYCLES=5, irq_o=1 iff IRQ_EN; W1C 0x4 clears TIMEOUT and irq_o.
//  3 START during RUN and during DRAIN -> ignored, CYCLES not reset; ABORT in RUN after 3
//    cycles -> DRAIN, TIMEOUT=1, DONE=0.
//  4 acc_done_i held high 4 cycles after start drops -> BUSY stays 1 for those 4 cycles;
//    START written then ignored; next START after release accepted.
//  5 Same-cycle W1C of DONE and done event -> DONE reads 1; done and TLIMIT expiry same
//    cycle -> DONE=1, TIMEOUT=0.
//  6 rst_n low mid-RUN -> acc_start_o, irq_o, all registers 0 immediately; reads of
//    0x0..0xC return 0; unmapped read returns 0 with rvalid 1 cycle after req.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the matrix-multiply accelerator controller.
//   - Byte offsets of the four registers in the register window.
//   - Bit positions inside CTRL and STATUS.
//   - FSM state encoding used by acc_ctrl.
package acc_pkg;

  localparam logic [7:0] ACC_CTRL_OFFS   = 8'h00;
  localparam logic [7:0] ACC_STATUS_OFFS = 8'h04;
  localparam logic [7:0] ACC_CYCLES_OFFS = 8'h08;
  localparam logic [7:0] ACC_TLIMIT_OFFS = 8'h0C;

  // CTRL bits
  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_ABORT_BIT  = 2;

  // STATUS bits
  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_DONE_BIT    = 1;
  localparam int unsigned STAT_TIMEOUT_BIT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

endpackage

// File: rtl/acc_ctrl_regs.sv
// Register file of the accelerator controller.
//   Decodes the req/gnt/rvalid register bus, stores IRQ_EN, DONE, TIMEOUT and
//   TLIMIT, and returns read data one cycle after each granted access.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   reg_*_i / reg_*_o register bus (gnt is combinational, rvalid/rdata registered)
//   busy_i            FSM is in RUN or DRAIN
//   cycles_i          current CYCLES counter value
//   set_done_i        FSM strobe: run finished with acc_done
//   set_timeout_i     FSM strobe: run stopped by timeout or abort
//   clr_status_i      FSM strobe: a START was accepted, clear DONE/TIMEOUT
//   start_o / abort_o single-cycle pulses from CTRL writes
//   tlimit_o          current TLIMIT value
//   irq_o             IRQ_EN & (DONE | TIMEOUT)
module acc_ctrl_regs
  import acc_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_req_i,
  input  logic              reg_we_i,
  input  logic [ADDR_W-1:0] reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  output logic              reg_gnt_o,
  output logic              reg_rvalid_o,
  output logic [31:0]       reg_rdata_o,
  input  logic              busy_i,
  input  logic [CNT_W-1:0]  cycles_i,
  input  logic              set_done_i,
  input  logic              set_timeout_i,
  input  logic              clr_status_i,
  output logic              start_o,
  output logic              abort_o,
  output logic [CNT_W-1:0]  tlimit_o,
  output logic              irq_o
);

  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  tlimit_q, tlimit_d;
  logic              rvalid_q;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] addr_word;
  logic              sel_ctrl, sel_status, sel_cycles, sel_tlimit;
  logic              wr, rd;
  logic              unused_addr_bits;

  // Byte-lane bits carry no meaning; the upper bits must match exactly so
  // anything beyond 0xC in a wider window is unmapped.
  assign addr_word        = {reg_addr_i[ADDR_W-1:2], 2'b00};
  assign unused_addr_bits = ^reg_addr_i[1:0];

  assign sel_ctrl   = (addr_word == ADDR_W'(ACC_CTRL_OFFS));
  assign sel_status = (addr_word == ADDR_W'(ACC_STATUS_OFFS));
  assign sel_cycles = (addr_word == ADDR_W'(ACC_CYCLES_OFFS));
  assign sel_tlimit = (addr_word == ADDR_W'(ACC_TLIMIT_OFFS));

  assign wr = reg_req_i & reg_we_i;
  assign rd = reg_req_i & ~reg_we_i;

  // Always ready: every request is granted in the cycle it is presented.
  assign reg_gnt_o = reg_req_i;

  assign start_o = wr & sel_ctrl & reg_wdata_i[CTRL_START_BIT];
  assign abort_o = wr & sel_ctrl & reg_wdata_i[CTRL_ABORT_BIT];

  always_comb begin
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    tlimit_d  = tlimit_q;

    if (wr && sel_ctrl) begin
      irq_en_d = reg_wdata_i[CTRL_IRQ_EN_BIT];
    end
    if (wr && sel_tlimit) begin
      tlimit_d = reg_wdata_i[CNT_W-1:0];
    end

    // Hardware set beats both the start-clear and a software W1C.
    if (set_done_i) begin
      done_d = 1'b1;
    end else if (clr_status_i || (wr && sel_status && reg_wdata_i[STAT_DONE_BIT])) begin
      done_d = 1'b0;
    end

    if (set_timeout_i) begin
      timeout_d = 1'b1;
    end else if (clr_status_i || (wr && sel_status && reg_wdata_i[STAT_TIMEOUT_BIT])) begin
      timeout_d = 1'b0;
    end
  end

  // Read data reflects register contents at the cycle the request is granted.
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (sel_ctrl) begin
        rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
      end else if (sel_status) begin
        rdata_d[STAT_BUSY_BIT]    = busy_i;
        rdata_d[STAT_DONE_BIT]    = done_q;
        rdata_d[STAT_TIMEOUT_BIT] = timeout_q;
      end else if (sel_cycles) begin
        rdata_d = 32'(cycles_i);
      end else if (sel_tlimit) begin
        rdata_d = 32'(tlimit_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      tlimit_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      tlimit_q  <= tlimit_d;
      rvalid_q  <= reg_req_i;
      rdata_q   <= rdata_d;
    end
  end

  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign tlimit_o     = tlimit_q;
  assign irq_o        = irq_en_q & (done_q | timeout_q);

endmodule

// File: rtl/acc_ctrl.sv
// Sequencer for the matrix-multiply accelerator.
//   Holds acc_start_o high while a run is in progress, counts run cycles,
//   stops on acc_done_i, timeout or ABORT, and waits for the accelerator to
//   release acc_done_i before accepting the next START.
// Handshake: the register bus is req/gnt/rvalid. gnt equals req (always
//   ready); every granted access (read or write) returns exactly one rvalid
//   pulse one cycle later, with rdata = read value for reads and 0 otherwise.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reg_req_i .. reg_rdata_o register bus
//   acc_start_o             registered start level to the accelerator
//   acc_done_i              done level from the accelerator
//   irq_o                   level interrupt
module acc_ctrl
  import acc_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_req_i,
  input  logic              reg_we_i,
  input  logic [ADDR_W-1:0] reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  output logic              reg_gnt_o,
  output logic              reg_rvalid_o,
  output logic [31:0]       reg_rdata_o,
  output logic              acc_start_o,
  input  logic              acc_done_i,
  output logic              irq_o
);

  acc_state_e        state_q;
  logic [CNT_W-1:0]  cycles_q;
  logic              acc_start_q;

  logic              start_pulse, abort_pulse;
  logic [CNT_W-1:0]  tlimit;
  logic              busy;
  logic              accept_start;
  logic              tmo_hit;
  logic              set_done, set_timeout;
  logic [CNT_W-1:0]  cycles_inc;

  acc_ctrl_regs #(
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) u_regs (
    .clk           (clk),
    .rst_n         (rst_n),
    .reg_req_i     (reg_req_i),
    .reg_we_i      (reg_we_i),
    .reg_addr_i    (reg_addr_i),
    .reg_wdata_i   (reg_wdata_i),
    .reg_gnt_o     (reg_gnt_o),
    .reg_rvalid_o  (reg_rvalid_o),
    .reg_rdata_o   (reg_rdata_o),
    .busy_i        (busy),
    .cycles_i      (cycles_q),
    .set_done_i    (set_done),
    .set_timeout_i (set_timeout),
    .clr_status_i  (accept_start),
    .start_o       (start_pulse),
    .abort_o       (abort_pulse),
    .tlimit_o      (tlimit),
    .irq_o         (irq_o)
  );

  assign busy = (state_q != IDLE);

  // A START while the accelerator still holds done would restart it before
  // it has been released, so it is dropped.
  assign accept_start = (state_q == IDLE) && start_pulse && !acc_done_i;

  // Timeout fires in the last allowed RUN cycle so that CYCLES ends at TLIMIT.
  assign tmo_hit = (tlimit != '0) && (cycles_q == tlimit - CNT_W'(1));

  // Done takes priority over timeout/abort in the same cycle.
  assign set_done    = (state_q == RUN) && acc_done_i;
  assign set_timeout = (state_q == RUN) && !acc_done_i && (abort_pulse || tmo_hit);

  assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cycles_q    <= '0;
      acc_start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_start) begin
            state_q     <= RUN;
            cycles_q    <= '0;
            acc_start_q <= 1'b1;
          end
        end
        RUN: begin
          cycles_q <= cycles_inc;
          if (set_done || set_timeout) begin
            state_q     <= DRAIN;
            acc_start_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (!acc_done_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign acc_start_o = acc_start_q;

endmodule

// File: tb/tb_acc_ctrl.sv
// Bench for acc_ctrl: directed register-bus sequences with hand-computed
// expectations, a behavioural accelerator, and a scoreboard monitor that
// checks every rvalid response against the queued expectation.
module tb_acc_ctrl;

  localparam int CNT_W  = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] A_CTRL   = 5'h00;
  localparam logic [ADDR_W-1:0] A_STATUS = 5'h04;
  localparam logic [ADDR_W-1:0] A_CYCLES = 5'h08;
  localparam logic [ADDR_W-1:0] A_TLIMIT = 5'h0C;

  logic              clk;
  logic              rst_n;
  logic              reg_req_i;
  logic              reg_we_i;
  logic [ADDR_W-1:0] reg_addr_i;
  logic [31:0]       reg_wdata_i;
  logic              reg_gnt_o;
  logic              reg_rvalid_o;
  logic [31:0]       reg_rdata_o;
  logic              acc_start_o;
  logic              acc_done_i;
  logic              irq_o;

  acc_ctrl #(
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_req_i    (reg_req_i),
    .reg_we_i     (reg_we_i),
    .reg_addr_i   (reg_addr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_gnt_o    (reg_gnt_o),
    .reg_rvalid_o (reg_rvalid_o),
    .reg_rdata_o  (reg_rdata_o),
    .acc_start_o  (acc_start_o),
    .acc_done_i   (acc_done_i),
    .irq_o        (irq_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int start_hi = 0;
  always @(negedge clk) if (acc_start_o) start_hi++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reg_rvalid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rdata 0x%08h, expected no response", reg_rdata_o);
      end else begin
        logic [31:0] e;
        string       nm;
        int          ec;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        ec = cyc_q.pop_front();
        check(nm, reg_rdata_o, e);
        check({nm, "_latency"}, cyc, ec);
      end
    end
  end

  // ---------------- accelerator model ----------------
  // done_delay < 0: never asserts done. Otherwise done rises done_delay
  // cycles after acc_start_o rises and is held done_hold cycles after
  // acc_start_o drops.
  int done_delay = -1;
  int done_hold  = 0;

  initial begin
    int run_cnt;
    int hold_cnt;
    acc_done_i = 1'b0;
    run_cnt    = 0;
    hold_cnt   = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        acc_done_i = 1'b0;
        run_cnt    = 0;
        hold_cnt   = 0;
      end else if (acc_start_o) begin
        run_cnt++;
        hold_cnt = 0;
        if (done_delay >= 0 && run_cnt > done_delay) acc_done_i = 1'b1;
      end else begin
        run_cnt = 0;
        if (acc_done_i) begin
          hold_cnt++;
          if (hold_cnt > done_hold) begin
            acc_done_i = 1'b0;
            hold_cnt   = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus(input logic we, input logic [ADDR_W-1:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp, input string name);
    reg_req_i   = 1'b1;
    reg_we_i    = we;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    exp_q.push_back(we ? 32'h0 : exp);
    name_q.push_back(name);
    cyc_q.push_back(cyc + 1);
    #1;
    check({name, "_gnt"}, {31'h0, reg_gnt_o}, 32'h1);
    @(posedge clk);
    #1;
    reg_req_i   = 1'b0;
    reg_we_i    = 1'b0;
    reg_wdata_i = '0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    bus(1'b1, addr, data, 32'h0, "wr_resp");
  endtask

  task automatic rd(input logic [ADDR_W-1:0] addr, input logic [31:0] exp, input string name);
    bus(1'b0, addr, 32'h0, exp, name);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_run_end(input string name);
    for (int i = 0; i < 100 && acc_start_o; i++) idle(1);
    check({name, "_run_end"}, {31'h0, acc_start_o}, 32'h0);
  endtask

  task automatic wait_release(input string name);
    for (int i = 0; i < 100 && acc_done_i; i++) idle(1);
    check({name, "_release"}, {31'h0, acc_done_i}, 32'h0);
    idle(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    rst_n       = 1'b0;
    reg_req_i   = 1'b0;
    reg_we_i    = 1'b0;
    reg_addr_i  = '0;
    reg_wdata_i = '0;
    idle(3);
    check("rst_acc_start", {31'h0, acc_start_o}, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    check("rst_rvalid", {31'h0, reg_rvalid_o}, 32'h0);
    check("rst_rdata", reg_rdata_o, 32'h0);
    rst_n = 1'b1;
    idle(2);
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_STATUS, 32'h0, "rst_status");
    rd(A_CYCLES, 32'h0, "rst_cycles");
    rd(A_TLIMIT, 32'h0, "rst_tlimit");

    // Test 1: normal completion, done 10 cycles after start.
    done_delay = 10;
    done_hold  = 0;
    wr(A_TLIMIT, 32'h0);
    s0 = start_hi;
    wr(A_CTRL, 32'h3);
    check("t1_start_next_cycle", {31'h0, acc_start_o}, 32'h1);
    wait_run_end("t1");
    wait_release("t1");
    check("t1_start_cycles", start_hi - s0, 32'd11);
    check("t1_irq", {31'h0, irq_o}, 32'h1);
    rd(A_STATUS, 32'h2, "t1_status");
    rd(A_CYCLES, 32'd11, "t1_cycles");
    rd(A_CTRL, 32'h2, "t1_ctrl");

    // Test 2: timeout with TLIMIT=5, IRQ_EN off then on.
    done_delay = -1;
    wr(A_TLIMIT, 32'd5);
    s0 = start_hi;
    wr(A_CTRL, 32'h1);
    wait_run_end("t2");
    idle(2);
    check("t2_start_cycles", start_hi - s0, 32'd5);
    check("t2_irq_disabled", {31'h0, irq_o}, 32'h0);
    rd(A_STATUS, 32'h4, "t2_status");
    rd(A_CYCLES, 32'd5, "t2_cycles");
    wr(A_CTRL, 32'h2);
    check("t2_irq_enabled", {31'h0, irq_o}, 32'h1);
    wr(A_STATUS, 32'h4);
    check("t2_irq_after_w1c", {31'h0, irq_o}, 32'h0);
    rd(A_STATUS, 32'h0, "t2_status_w1c");

    // Test 3: START in RUN and DRAIN ignored; ABORT after 3 RUN cycles.
    wr(A_TLIMIT, 32'h0);
    s0 = start_hi;
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h1);
    idle(1);
    wr(A_CTRL, 32'h4);
    wr(A_CTRL, 32'h1);
    idle(3);
    check("t3_start_cycles", start_hi - s0, 32'd3);
    check("t3_start_low", {31'h0, acc_start_o}, 32'h0);
    rd(A_CYCLES, 32'd3, "t3_cycles");
    rd(A_STATUS, 32'h4, "t3_status");

    // Test 4: done held 4 cycles after start drops.
    done_delay = 2;
    done_hold  = 4;
    s0 = start_hi;
    wr(A_CTRL, 32'h1);
    wait_run_end("t4");
    rd(A_STATUS, 32'h3, "t4_status_drain_a");
    wr(A_CTRL, 32'h1);
    rd(A_STATUS, 32'h3, "t4_status_drain_b");
    wait_release("t4");
    check("t4_start_cycles", start_hi - s0, 32'd3);
    rd(A_STATUS, 32'h2, "t4_status_idle");
    rd(A_CYCLES, 32'd3, "t4_cycles");
    done_delay = 1;
    done_hold  = 0;
    s0 = start_hi;
    wr(A_CTRL, 32'h1);
    wait_run_end("t4b");
    wait_release("t4b");
    check("t4b_start_cycles", start_hi - s0, 32'd2);
    rd(A_CYCLES, 32'd2, "t4b_cycles");

    // Test 5a: W1C of DONE in the same cycle as the done event.
    done_delay = 3;
    s0 = start_hi;
    wr(A_CTRL, 32'h3);
    idle(3);
    wr(A_STATUS, 32'h2);
    wait_run_end("t5a");
    wait_release("t5a");
    check("t5a_start_cycles", start_hi - s0, 32'd4);
    rd(A_STATUS, 32'h2, "t5a_status");

    // Test 5b: done and TLIMIT expiry in the same cycle.
    wr(A_TLIMIT, 32'd4);
    s0 = start_hi;
    wr(A_CTRL, 32'h3);
    wait_run_end("t5b");
    wait_release("t5b");
    check("t5b_start_cycles", start_hi - s0, 32'd4);
    rd(A_STATUS, 32'h2, "t5b_status");
    rd(A_CYCLES, 32'd4, "t5b_cycles");
    check("t5b_irq", {31'h0, irq_o}, 32'h1);

    // Test 6: asynchronous reset in the middle of a run.
    done_delay = -1;
    wr(A_TLIMIT, 32'd100);
    wr(A_CTRL, 32'h3);
    idle(3);
    check("t6_running", {31'h0, acc_start_o}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_acc_start", {31'h0, acc_start_o}, 32'h0);
    check("t6_rst_irq", {31'h0, irq_o}, 32'h0);
    check("t6_rst_rvalid", {31'h0, reg_rvalid_o}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rd(A_CTRL, 32'h0, "t6_ctrl");
    rd(A_STATUS, 32'h0, "t6_status");
    rd(A_CYCLES, 32'h0, "t6_cycles");
    rd(A_TLIMIT, 32'h0, "t6_tlimit");
    rd(5'h10, 32'h0, "t6_unmapped_rd");
    wr(5'h1C, 32'h55);
    rd(A_TLIMIT, 32'h0, "t6_unmapped_wr");
    wr(5'h0E, 32'h77);
    rd(A_TLIMIT, 32'h77, "t6_byte_lane_alias");

    idle(4);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
